// File: rtl/spi_master_shift.sv
// Mode-0 SPI master shift engine paced by edges of an upstream divider output.
// Define SPI_LSB_FIRST_EN for LSB-first shifting; MSB-first otherwise.
module spi_master_shift #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clock_in,
    input  logic                  i_reset_n,
    input  logic                  i_div_clock,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_miso,
    output logic                  o_sclk,
    output logic                  o_mosi,
    output logic                  o_cs_n,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_rx_data
);

    localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD
    } state_t;

    state_t                r_state, r_state_nx;
    logic                  r_div_q;
    logic                  r_sclk, r_sclk_nx;
    logic                  r_mosi, r_mosi_nx;
    logic                  r_cs_n, r_cs_n_nx;
    logic                  r_busy, r_busy_nx;
    logic                  r_done, r_done_nx;
    logic [CW-1:0]         r_cnt, r_cnt_nx;
    logic [DATA_WIDTH-1:0] r_tx_sr, r_tx_sr_nx;
    logic [DATA_WIDTH-1:0] r_rx_sr, r_rx_sr_nx;
    logic [DATA_WIDTH-1:0] r_rx_data, r_rx_data_nx;

    logic                  w_step;
    logic                  w_last;
    logic                  w_first_bit;
    logic [DATA_WIDTH-1:0] w_tx_next;
    logic [DATA_WIDTH-1:0] w_rx_next;
    logic                  w_next_bit;

    assign w_step = i_div_clock ^ r_div_q;
    assign w_last = (r_cnt == CW'(DATA_WIDTH - 1));

`ifdef SPI_LSB_FIRST_EN
    assign w_first_bit = i_tx_data[0];
    assign w_tx_next   = {1'b0, r_tx_sr[DATA_WIDTH-1:1]};
    assign w_next_bit  = w_tx_next[0];
    assign w_rx_next   = {i_miso, r_rx_sr[DATA_WIDTH-1:1]};
`else
    assign w_first_bit = i_tx_data[DATA_WIDTH-1];
    assign w_tx_next   = {r_tx_sr[DATA_WIDTH-2:0], 1'b0};
    assign w_next_bit  = w_tx_next[DATA_WIDTH-1];
    assign w_rx_next   = {r_rx_sr[DATA_WIDTH-2:0], i_miso};
`endif

    always_ff @(posedge i_clock_in or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= S_IDLE;
            r_div_q   <= 1'b0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_rx_data <= '0;
        end else begin
            r_state   <= r_state_nx;
            r_div_q   <= i_div_clock;
            r_sclk    <= r_sclk_nx;
            r_mosi    <= r_mosi_nx;
            r_cs_n    <= r_cs_n_nx;
            r_busy    <= r_busy_nx;
            r_done    <= r_done_nx;
            r_cnt     <= r_cnt_nx;
            r_tx_sr   <= r_tx_sr_nx;
            r_rx_sr   <= r_rx_sr_nx;
            r_rx_data <= r_rx_data_nx;
        end
    end

    always_comb begin
        r_state_nx   = r_state;
        r_sclk_nx    = r_sclk;
        r_mosi_nx    = r_mosi;
        r_cs_n_nx    = r_cs_n;
        r_busy_nx    = r_busy;
        r_done_nx    = 1'b0;
        r_cnt_nx     = r_cnt;
        r_tx_sr_nx   = r_tx_sr;
        r_rx_sr_nx   = r_rx_sr;
        r_rx_data_nx = r_rx_data;
        unique case (r_state)
            S_IDLE: begin
                r_sclk_nx = 1'b0;
                r_cs_n_nx = 1'b1;
                r_mosi_nx = 1'b0;
                r_busy_nx = 1'b0;
                if (i_start) begin
                    r_state_nx = S_SETUP;
                    r_tx_sr_nx = i_tx_data;
                    r_rx_sr_nx = '0;
                    r_cnt_nx   = '0;
                    r_cs_n_nx  = 1'b0;
                    r_mosi_nx  = w_first_bit;
                    r_busy_nx  = 1'b1;
                end
            end
            S_SETUP: begin
                if (w_step) begin
                    r_state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_step) begin
                    if (!r_sclk) begin
                        r_sclk_nx  = 1'b1;
                        r_rx_sr_nx = w_rx_next;
                    end else begin
                        r_sclk_nx = 1'b0;
                        if (w_last) begin
                            r_state_nx = S_HOLD;
                        end else begin
                            r_cnt_nx   = r_cnt + CW'(1);
                            r_tx_sr_nx = w_tx_next;
                            r_mosi_nx  = w_next_bit;
                        end
                    end
                end
            end
            S_HOLD: begin
                // Stay in HOLD through the done cycle so a start there is ignored.
                if (r_done) begin
                    r_state_nx = S_IDLE;
                    r_busy_nx  = 1'b0;
                end else if (w_step) begin
                    r_cs_n_nx    = 1'b1;
                    r_mosi_nx    = 1'b0;
                    r_rx_data_nx = r_rx_sr;
                    r_done_nx    = 1'b1;
                end
            end
            default: begin
                r_state_nx = S_IDLE;
            end
        endcase
    end

    assign o_sclk    = r_sclk;
    assign o_mosi    = r_mosi;
    assign o_cs_n    = r_cs_n;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_rx_data = r_rx_data;

endmodule
